// File: rtl/ft232h_pkg.sv
// Shared types and constants for the ft232h byte packetizer.
package ft232h_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StSeq,
        StLen,
        StSampleHi,
        StSampleLo,
        StCsum
    } pkt_state_e;

    localparam logic [7:0] FT232H_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/ft232h_packetizer.sv
// Frames 16-bit samples into byte packets (SYNC, SEQ, LEN, samples MSB-first, XOR checksum)
// for the ft232h controller's AXIS byte input.
module ft232h_packetizer
    import ft232h_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_PACKET = 4,
    parameter logic [7:0]  SYNC_BYTE          = FT232H_SYNC_BYTE
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        busy
);

    localparam logic [7:0] LenByte = 8'(2 * SAMPLES_PER_PACKET);
    localparam logic [6:0] LastIdx = 7'(SAMPLES_PER_PACKET - 1);

    pkt_state_e  state_q, state_d;
    logic [15:0] hold_data_q;
    logic        hold_full_q;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  csum_q, csum_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        busy_q, busy_d;
    logic        slot_free;
    logic        accept;
    logic        lo_load;

    assign slot_free = !m_tvalid_q || m_tready;
    assign accept    = s_tvalid && !hold_full_q;
    assign s_tready  = !hold_full_q;
    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign busy      = busy_q;

    // State names the byte currently held in the output register.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        csum_d     = csum_q;
        idx_d      = idx_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        busy_d     = busy_q;
        lo_load    = 1'b0;
        if (slot_free) begin
            m_tvalid_d = 1'b0;
            unique case (state_q)
                StIdle, StCsum: begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                    // A waiting sample starts the next packet with no gap after CSUM.
                    if (hold_full_q) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = SYNC_BYTE;
                        busy_d     = 1'b1;
                        csum_d     = 8'h00;
                        idx_d      = 7'd0;
                        state_d    = StSync;
                    end
                end
                StSync: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = seq_q;
                    csum_d     = csum_q ^ seq_q;
                    state_d    = StSeq;
                end
                StSeq: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = LenByte;
                    csum_d     = csum_q ^ LenByte;
                    state_d    = StLen;
                end
                StLen: begin
                    if (hold_full_q) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = hold_data_q[15:8];
                        csum_d     = csum_q ^ hold_data_q[15:8];
                        state_d    = StSampleHi;
                    end
                end
                StSampleHi: begin
                    if (hold_full_q) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = hold_data_q[7:0];
                        csum_d     = csum_q ^ hold_data_q[7:0];
                        lo_load    = 1'b1;
                        state_d    = StSampleLo;
                    end
                end
                StSampleLo: begin
                    if (idx_q < LastIdx) begin
                        // Starved: output drops valid and waits for the next sample.
                        if (hold_full_q) begin
                            m_tvalid_d = 1'b1;
                            m_tdata_d  = hold_data_q[15:8];
                            csum_d     = csum_q ^ hold_data_q[15:8];
                            idx_d      = idx_q + 7'd1;
                            state_d    = StSampleHi;
                        end
                    end else begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = csum_q;
                        seq_d      = seq_q + 8'd1;
                        state_d    = StCsum;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_data_q <= 16'h0000;
        end else if (accept) begin
            hold_full_q <= 1'b1;
            hold_data_q <= s_tdata;
        end else if (lo_load) begin
            hold_full_q <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            seq_q      <= 8'h00;
            csum_q     <= 8'h00;
            idx_q      <= 7'd0;
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            busy_q     <= busy_d;
        end
    end

endmodule
